// File: rtl/immediate_decode_unit_pkg.sv
// Shared format codes and RISC-V major opcodes for the immediate decode unit.
package immediate_decode_unit_pkg;

    typedef enum logic [2:0] {
        FmtR       = 3'd0,
        FmtI       = 3'd1,
        FmtS       = 3'd2,
        FmtB       = 3'd3,
        FmtU       = 3'd4,
        FmtJ       = 3'd5,
        FmtIllegal = 3'd7
    } fmt_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpImm32  = 7'b0011011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;

endpackage

// File: rtl/immediate_decode_unit_decode.sv
// Purely combinational immediate extraction and format classification of one
// RISC-V instruction word.
module imm_format_decode
    import immediate_decode_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic            illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_shift;
    logic [31:0] imm32;
    logic [31:0] imm_i;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign imm_i    = {{20{instr_i[31]}}, instr_i[31:20]};

    always_comb begin
        imm32     = '0;
        fmt_o     = FmtIllegal;
        illegal_o = 1'b1;
        case (opcode)
            OpLoad, OpJalr: begin
                fmt_o     = FmtI;
                illegal_o = 1'b0;
                imm32     = imm_i;
            end
            OpImm: begin
                fmt_o     = FmtI;
                illegal_o = 1'b0;
                imm32     = imm_i;
                // Shift amounts are unsigned; RV64 widens shamt by one bit.
                if (is_shift) begin
                    if (XLEN == 64) imm32 = {26'd0, instr_i[25:20]};
                    else            imm32 = {27'd0, instr_i[24:20]};
                end
            end
            OpImm32: begin
                if (XLEN == 64) begin
                    fmt_o     = FmtI;
                    illegal_o = 1'b0;
                    imm32     = imm_i;
                end
            end
            OpStore: begin
                fmt_o     = FmtS;
                illegal_o = 1'b0;
                imm32     = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OpBranch: begin
                fmt_o     = FmtB;
                illegal_o = 1'b0;
                imm32     = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                             instr_i[11:8], 1'b0};
            end
            OpLui, OpAuipc: begin
                fmt_o     = FmtU;
                illegal_o = 1'b0;
                imm32     = {instr_i[31:12], 12'd0};
            end
            OpJal: begin
                fmt_o     = FmtJ;
                illegal_o = 1'b0;
                imm32     = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                             instr_i[30:21], 1'b0};
            end
            OpReg: begin
                fmt_o     = FmtR;
                illegal_o = 1'b0;
            end
            default: ;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/immediate_decode_unit.sv
// Immediate decode unit: decodes each accepted instruction into a two-entry
// (output + skid) ready/valid pipeline and counts illegal opcodes.
module immediate_decode_unit
    import immediate_decode_unit_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [31:0]          instruction,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [XLEN-1:0]      outImmediate,
    output logic [2:0]           outFormat,
    output logic                 outIllegal,
    input  logic                 clearCount,
    output logic [CNT_WIDTH-1:0] illegalCount
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    localparam entry_t EntryReset = '{imm: '0, fmt: FmtR, illegal: 1'b0};

    logic [XLEN-1:0]      dec_imm;
    fmt_e                 dec_fmt;
    logic                 dec_illegal;
    entry_t               dec;
    entry_t               out_q, out_d, skid_q, skid_d;
    logic                 out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic                 live_q;
    logic                 accept, deliver;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    imm_format_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr_i  (instruction),
        .imm_o    (dec_imm),
        .fmt_o    (dec_fmt),
        .illegal_o(dec_illegal)
    );

    assign dec = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};

    // live_q holds inReady low until the first edge after reset release.
    assign inReady = live_q & ~skid_valid_q;
    assign accept  = inValid & inReady;
    assign deliver = out_valid_q & outReady;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (deliver || !out_valid_q) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clearCount) begin
            count_d = '0;
        end else if (accept && dec_illegal && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            out_q        <= EntryReset;
            skid_q       <= EntryReset;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            live_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            live_q       <= 1'b1;
            count_q      <= count_d;
        end
    end

    assign outValid     = out_valid_q;
    assign outImmediate = out_q.imm;
    assign outFormat    = out_q.fmt;
    assign outIllegal   = out_q.illegal;
    assign illegalCount = count_q;

endmodule

// File: doc/immediate_decode_unit.md
IMMEDIATE_DECODE_UNIT -- requirements
Module: immediate_decode_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32 and 64 only.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the illegal-instruction counter.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port inValid, input, 1, instruction word valid.
REQ-006 SHALL have port inReady, output, 1, unit can accept an instruction.
REQ-007 SHALL have port instruction, input, 32, raw RISC-V instruction word.
REQ-008 SHALL have port outValid, output, 1, result valid.
REQ-009 SHALL have port outReady, input, 1, consumer accepts the result.
REQ-010 SHALL have port outImmediate, output, XLEN, sign-extended immediate.
REQ-011 SHALL have port outFormat, output, 3, decoded format code.
REQ-012 SHALL have port outIllegal, output, 1, opcode not recognised.
REQ-013 SHALL have port clearCount, input, 1, synchronous counter clear.
REQ-014 SHALL have port illegalCount, output, CNT_WIDTH, count of accepted illegal instructions.

Function
REQ-015 SHALL accept an instruction on any cycle with inValid and inReady both high, and deliver it on any cycle with outValid and outReady both high.
REQ-016 SHALL present an accepted instruction at the outputs exactly one cycle after acceptance when the output stage is empty or draining.
REQ-017 SHALL hold outImmediate, outFormat and outIllegal stable while outValid is high and outReady is low.
REQ-018 SHALL buffer two entries: output register plus skid register; inReady is high exactly when the skid register is empty; this gives full throughput with no combinational path from outReady to inReady.
REQ-019 SHALL deliver results in acceptance order, with no loss or duplication under any outReady pattern.
REQ-020 SHALL decode opcode instruction[6:0] as follows. I-type: 0000011, 0010011, 1100111, and 0011011 only when XLEN=64. S-type: 0100011. B-type: 1100011. U-type: 0110111 and 0010111. J-type: 1101111. R-type: 0110011, which gives immediate zero and outIllegal=0.
REQ-021 SHALL build immediates per the RV spec:
- I: inst[31:20].
- S: {inst[31:25], inst[11:7]}.
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U: {inst[31:12], 12 zeros}.
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Every format is sign-extended from its top bit to XLEN.
REQ-022 SHALL produce the zero-extended shift amount for opcode 0010011 with funct3 001 or 101: inst[24:20] when XLEN=32, inst[25:20] when XLEN=64.
REQ-023 SHALL output outFormat=ILLEGAL, outIllegal=1 and outImmediate=0 for any other opcode, including 0011011 when XLEN=32.
REQ-024 SHALL increment illegalCount by one on each accepted illegal instruction, saturating at all-ones.
REQ-025 SHALL clear illegalCount to 0 when clearCount is high; clear takes priority over a simultaneous increment.

Reset
REQ-026 SHALL, while resetN is low, immediately force outValid=0, inReady=0, illegalCount=0, outImmediate=0, outFormat=R and outIllegal=0, and empty both buffer entries.
REQ-027 SHALL set inReady=1 on the first clock edge after resetN deasserts; entries in flight when reset asserts are discarded.

Structure
REQ-028 SHALL take its format codes from a shared package: R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7. Opcode constants also come from that package.
REQ-029 SHALL put the combinational decode in one sub-module, imm_format_decode (instruction in; immediate, format and illegal out); handshake and buffering stay in the top module.

Verification
REQ-030 The bench SHALL cover: XLEN=32, input 0xFFC12083 (lw) -> outImmediate 0xFFFFFFFC, outFormat=1, one cycle after acceptance; input 0x40315093 (srai by 3) -> 0x00000003.
REQ-031 The bench SHALL cover: input 0xFE000EE3 (beq -4) -> 0xFFFFFFFC with format 3; input 0x123450B7 (lui) -> 0x12345000 with format 4; with XLEN=64, input 0x800000B7 -> 0xFFFFFFFF80000000.
REQ-032 The bench SHALL cover: outReady held low while three instructions are offered -> two accepted, inReady=0 with the third held; outReady then high -> all three emerge in order with stable data while stalled.
REQ-033 The bench SHALL cover: CNT_WIDTH=2, five accepted inputs of 0x0000007F -> outIllegal=1, outImmediate=0, illegalCount saturates at 3; clearCount asserted together with an illegal accept -> illegalCount=0.
REQ-034 The bench SHALL cover: resetN pulsed low with both entries full -> outValid=0 immediately, illegalCount=0, and nothing from the old entries is delivered after release.
